// File: rtl/wide_to_narrow_fifo_pkg.sv
// Shared helpers for the wide-write / narrow-read FIFO: a constant clog2 and
// the set of lane ratios the datapath supports.
package wide_to_narrow_fifo_pkg;

  // One bit per supported ratio value (1, 2, 4, 8).
  localparam logic [15:0] LEGAL_RATIO_MASK = 16'h0116;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  function automatic bit ratio_is_legal(input int unsigned ratio);
    return (ratio < 16) && LEGAL_RATIO_MASK[ratio[3:0]];
  endfunction

endpackage

// File: rtl/sdp_ram_wide_narrow.sv
// Simple dual-port storage: full-width write port, one-lane registered read
// port. The array itself is never reset so it maps onto block RAM; only the
// read output register is cleared.
module sdp_ram_wide_narrow #(
  parameter int WR_WIDTH = 64,
  parameter int RD_WIDTH = 16,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int LW       = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_wr_en,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic [WR_WIDTH-1:0] i_wr_data,
  input  logic                i_rd_en,
  input  logic [AW-1:0]       i_rd_word,
  input  logic [LW-1:0]       i_rd_lane,
  output logic [RD_WIDTH-1:0] o_rd_data
);

  logic [WR_WIDTH-1:0] r_mem [DEPTH];
  logic [RD_WIDTH-1:0] r_rd_data;

  // Write a whole word into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered lane read; holds its value when no read is issued.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_word][int'(i_rd_lane) * RD_WIDTH +: RD_WIDTH];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/wide_to_narrow_fifo.sv
// Wide-to-narrow FIFO: words of WR_WIDTH bits go in, RATIO lanes of
// WR_WIDTH/RATIO bits come out, lane 0 first. A partly drained word keeps its
// slot until its last lane is popped. All flags are registered from the
// post-operation pointer state.
module wide_to_narrow_fifo
  import wide_to_narrow_fifo_pkg::*;
#(
  parameter int  WR_WIDTH     = 64,
  parameter int  RATIO        = 4,
  parameter int  WR_DEPTH     = 32,
  parameter int  AFULL_THRESH = WR_DEPTH - 2,
  // An unsupported RATIO collapses LANES to 0 and stops elaboration here.
  localparam int LANES        = ratio_is_legal(RATIO) ? RATIO : 0,
  localparam int RD_WIDTH     = WR_WIDTH / LANES,
  localparam int LVL_W        = clog2(WR_DEPTH * RATIO) + 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [WR_WIDTH-1:0] din,
  output logic                full,
  output logic                almost_full,
  input  logic                rd_en,
  output logic [RD_WIDTH-1:0] dout,
  output logic                dout_valid,
  output logic                empty,
  output logic [LVL_W-1:0]    rd_level,
  output logic                overflow,
  output logic                underflow
);

  localparam int AW = clog2(WR_DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = (RATIO > 1) ? clog2(RATIO) : 1;

  localparam logic [PW-1:0] PTR_ONE     = PW'(1);
  localparam logic [PW-1:0] FULL_WORDS  = PW'(WR_DEPTH);
  localparam logic [PW-1:0] AFULL_WORDS = PW'(AFULL_THRESH);
  localparam logic [LW-1:0] LANE_ONE    = LW'(1);
  localparam logic [LW-1:0] LAST_LANE   = LW'(RATIO - 1);

  // Pointers carry one wrap bit so a full buffer differs from an empty one.
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rword;
  logic [LW-1:0]    r_rlane;
  logic             r_full;
  logic             r_afull;
  logic             r_empty;
  logic             r_ovf;
  logic             r_udf;
  logic             r_dvalid;
  logic [LVL_W-1:0] r_level;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [PW-1:0]    w_wptr_nxt;
  logic [PW-1:0]    w_rword_nxt;
  logic [LW-1:0]    w_rlane_nxt;
  logic [PW-1:0]    w_words_nxt;
  logic [LVL_W-1:0] w_level_nxt;

  // Accept/reject decisions from registered flags, then next pointer state.
  always_comb begin
    w_wr_acc    = wr_en & ~r_full & ~flush;
    w_rd_acc    = rd_en & ~r_empty & ~flush;
    w_wptr_nxt  = r_wptr;
    w_rword_nxt = r_rword;
    w_rlane_nxt = r_rlane;
    if (w_wr_acc) w_wptr_nxt = r_wptr + PTR_ONE;
    if (w_rd_acc) begin
      if (r_rlane == LAST_LANE) begin
        w_rlane_nxt = '0;
        w_rword_nxt = r_rword + PTR_ONE;
      end else begin
        w_rlane_nxt = r_rlane + LANE_ONE;
      end
    end
    w_words_nxt = w_wptr_nxt - w_rword_nxt;
    w_level_nxt = LVL_W'(w_words_nxt) * LVL_W'(RATIO) - LVL_W'(w_rlane_nxt);
  end

  // Pointer, level and flag registers; flush wins over same-cycle traffic.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr   <= '0;
      r_rword  <= '0;
      r_rlane  <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_dvalid <= 1'b0;
    end else if (flush) begin
      r_wptr   <= '0;
      r_rword  <= '0;
      r_rlane  <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_dvalid <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rword  <= w_rword_nxt;
      r_rlane  <= w_rlane_nxt;
      r_level  <= w_level_nxt;
      r_full   <= (w_words_nxt == FULL_WORDS);
      r_afull  <= (w_words_nxt >= AFULL_WORDS);
      r_empty  <= (w_level_nxt == '0);
      r_ovf    <= r_ovf | (wr_en & r_full);
      r_udf    <= r_udf | (rd_en & r_empty);
      r_dvalid <= w_rd_acc;
    end
  end

  sdp_ram_wide_narrow #(
    .WR_WIDTH (WR_WIDTH),
    .RD_WIDTH (RD_WIDTH),
    .DEPTH    (WR_DEPTH),
    .AW       (AW),
    .LW       (LW)
  ) u_ram (
    .clk       (clk),
    .resetn    (resetn),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wptr[AW-1:0]),
    .i_wr_data (din),
    .i_rd_en   (w_rd_acc),
    .i_rd_word (r_rword[AW-1:0]),
    .i_rd_lane (r_rlane),
    .o_rd_data (dout)
  );

  assign full        = r_full;
  assign almost_full = r_afull;
  assign empty       = r_empty;
  assign rd_level    = r_level;
  assign overflow    = r_ovf;
  assign underflow   = r_udf;
  assign dout_valid  = r_dvalid;

endmodule

// File: tb/tb_wide_to_narrow_fifo.sv
// Self-checking bench for wide_to_narrow_fifo (default parameters).
// A lane-queue reference model is checked every cycle; directed tables and
// sequences cover the documented corner cases.
module tb_wide_to_narrow_fifo;

  localparam int WR_WIDTH = 64;
  localparam int RATIO    = 4;
  localparam int RD_WIDTH = 16;
  localparam int WR_DEPTH = 32;
  localparam int LVL_W    = 8;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                flush = 1'b0;
  logic                wr_en = 1'b0;
  logic [WR_WIDTH-1:0] din = '0;
  logic                rd_en = 1'b0;
  logic                full, almost_full, dout_valid, empty, overflow, underflow;
  logic [RD_WIDTH-1:0] dout;
  logic [LVL_W-1:0]    rd_level;

  wide_to_narrow_fifo #(
    .WR_WIDTH     (WR_WIDTH),
    .RATIO        (RATIO),
    .WR_DEPTH     (WR_DEPTH),
    .AFULL_THRESH (WR_DEPTH - 2)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .wr_en       (wr_en),
    .din         (din),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .empty       (empty),
    .rd_level    (rd_level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of unread lanes, lane 0 of each word first.
  logic [RD_WIDTH-1:0] mq[$];
  logic                m_ovf, m_udf, m_valid;
  logic [RD_WIDTH-1:0] m_dout;

  function automatic int m_words();
    return (mq.size() + RATIO - 1) / RATIO;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_valid = 1'b0;
    m_dout  = '0;
  endtask

  task automatic model_step(input logic we, input logic re, input logic fl,
                            input logic [WR_WIDTH-1:0] d);
    bit was_full;
    bit was_empty;
    was_full  = (m_words() == WR_DEPTH);
    was_empty = (mq.size() == 0);
    m_valid   = 1'b0;
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (re) begin
        if (was_empty) m_udf = 1'b1;
        else begin
          m_dout  = mq.pop_front();
          m_valid = 1'b1;
        end
      end
      if (we) begin
        if (was_full) m_ovf = 1'b1;
        else for (int k = 0; k < RATIO; k++) mq.push_back(d[k*RD_WIDTH +: RD_WIDTH]);
      end
    end
  endtask

  task automatic check_model();
    chk("full",        full,        m_words() == WR_DEPTH);
    chk("almost_full", almost_full, m_words() >= WR_DEPTH - 2);
    chk("empty",       empty,       mq.size() == 0);
    chk("rd_level",    rd_level,    mq.size());
    chk("overflow",    overflow,    m_ovf);
    chk("underflow",   underflow,   m_udf);
    chk("dout_valid",  dout_valid,  m_valid);
    chk("dout",        dout,        m_dout);
  endtask

  // Drive at the falling edge, model the rising edge, check at next fall.
  task automatic cycle(input logic we, input logic re, input logic fl,
                       input logic [WR_WIDTH-1:0] d);
    wr_en = we; rd_en = re; flush = fl; din = d;
    @(posedge clk);
    model_step(we, re, fl, d);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    check_model();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic logic [WR_WIDTH-1:0] rnd_word();
    return {$urandom(), $urandom()};
  endfunction

  typedef struct {
    logic                we;
    logic                re;
    logic [WR_WIDTH-1:0] d;
    logic [LVL_W-1:0]    lvl;
    logic                emp;
    logic                vld;
    logic [RD_WIDTH-1:0] dq;
    logic                udf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{we:1'b1, re:1'b0, d:64'h8877665544332211, lvl:8'd4, emp:1'b0, vld:1'b0, dq:16'h0000, udf:1'b0};
    tbl[1] = '{we:1'b0, re:1'b1, d:64'h0, lvl:8'd3, emp:1'b0, vld:1'b1, dq:16'h2211, udf:1'b0};
    tbl[2] = '{we:1'b0, re:1'b1, d:64'h0, lvl:8'd2, emp:1'b0, vld:1'b1, dq:16'h4433, udf:1'b0};
    tbl[3] = '{we:1'b0, re:1'b1, d:64'h0, lvl:8'd1, emp:1'b0, vld:1'b1, dq:16'h6655, udf:1'b0};
    tbl[4] = '{we:1'b0, re:1'b1, d:64'h0, lvl:8'd0, emp:1'b1, vld:1'b1, dq:16'h8877, udf:1'b0};
    tbl[5] = '{we:1'b0, re:1'b1, d:64'h0, lvl:8'd0, emp:1'b1, vld:1'b0, dq:16'h8877, udf:1'b1};

    @(negedge clk);
    do_reset();

    // Lane ordering after a single write, then a read while empty.
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].we, tbl[i].re, 1'b0, tbl[i].d);
      chk("tbl_level", rd_level,   tbl[i].lvl);
      chk("tbl_empty", empty,      tbl[i].emp);
      chk("tbl_valid", dout_valid, tbl[i].vld);
      chk("tbl_dout",  dout,       tbl[i].dq);
      chk("tbl_udf",   underflow,  tbl[i].udf);
    end

    // Fill to full, overflow, then free a slot only on the last-lane pop.
    do_reset();
    for (int i = 0; i < WR_DEPTH; i++) begin
      cycle(1'b1, 1'b0, 1'b0, rnd_word());
      if (i == 28) chk("afull_29", almost_full, 1'b0);
      if (i == 29) chk("afull_30", almost_full, 1'b1);
      if (i == 30) chk("full_31",  full,        1'b0);
      if (i == 31) chk("full_32",  full,        1'b1);
    end
    cycle(1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("ovf_set",   overflow, 1'b1);
    chk("ovf_level", rd_level, 8'd128);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      chk("full_partial", full, 1'b1);
    end
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("full_released", full,     1'b0);
    chk("level_124",     rd_level, 8'd124);
    for (int i = 0; i < 124; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    chk("drained_empty", empty, 1'b1);

    // Simultaneous write and read on a partly drained word.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 64'h1111_2222_3333_4444);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("level_2", rd_level, 8'd2);
    cycle(1'b1, 1'b1, 1'b0, 64'h5555_6666_7777_8888);
    chk("level_5", rd_level, 8'd5);

    // Underflow on an empty FIFO.
    cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("udf_set",   underflow,  1'b1);
    chk("udf_valid", dout_valid, 1'b0);
    chk("udf_level", rd_level,   8'd0);

    // Flush with stored words and a concurrent write.
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, rnd_word());
    chk("pre_flush_level", rd_level, 8'd40);
    cycle(1'b1, 1'b0, 1'b1, rnd_word());
    chk("flush_empty", empty,     1'b1);
    chk("flush_level", rd_level,  8'd0);
    chk("flush_udf",   underflow, 1'b0);
    chk("flush_ovf",   overflow,  1'b0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("flush_dropped", underflow, 1'b1);

    // Randomized traffic with varying write/read bias and rare flushes.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      case ((i / 300) % 3)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 30; rp = 80; end
        default: begin wp = 60; rp = 60; end
      endcase
      cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
            $urandom_range(0, 299) == 0, rnd_word());
    end

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, rnd_word());
    wr_en = 1'b1; rd_en = 1'b1; din = rnd_word();
    #2 resetn = 1'b0;
    model_reset();
    #1 check_model();
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check_model();
    resetn = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 64'h0123456789ABCDEF);
    cycle(1'b0, 1'b1, 1'b0, '0);
    chk("post_reset_lane0", dout,       16'hCDEF);
    chk("post_reset_valid", dout_valid, 1'b1);
    chk("post_reset_level", rd_level,   8'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
